// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiply sequencer: WIDTH cycles in ADD, out_valid WIDTH+1 clocks after accept.
// Single operation in flight (in_ready only in IDLE); SEQ_MULT_ZERO_BYPASS_EN skips ADD on a zero operand.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;

  assign add_cin = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      out_prod <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      mcand    <= mcand_nxt;
      cnt      <= cnt_nxt;
      out_prod <= prod_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mcand_nxt = mcand;
    cnt_nxt   = cnt;
    prod_nxt  = out_prod;
    add_a     = '0;
    add_b     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          mcand_nxt = in_a;
          acc_nxt   = {{WIDTH{1'b0}}, in_b};
          cnt_nxt   = CW'(WIDTH);
          state_nxt = ADD;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
          if (in_a == '0 || in_b == '0) begin
            prod_nxt  = '0;
            state_nxt = DONE;
          end
`endif
        end
      end
      ADD: begin
        // multiplier bits sit in the low half and shift out as the product shifts in
        add_a   = acc[2*WIDTH-1:WIDTH];
        add_b   = acc[0] ? mcand : '0;
        acc_nxt = {add_cout, add_sum, acc[WIDTH-1:1]};
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          prod_nxt  = acc_nxt;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl at WIDTH=8 and WIDTH=16 with an ideal adder row and an arithmetic product model.
module tb_seq_mult_ctrl;

`ifdef SEQ_MULT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid, in_ready, add_cin, add_cout, out_valid, out_ready;
  logic [7:0]  in_a, in_b, add_a, add_b, add_sum;
  logic [15:0] out_prod;

  logic        w_in_valid, w_in_ready, w_add_cin, w_add_cout, w_out_valid, w_out_ready;
  logic [15:0] w_in_a, w_in_b, w_add_a, w_add_b, w_add_sum;
  logic [31:0] w_out_prod;

  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
  assign {w_add_cout, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + {16'b0, w_add_cin};

  seq_mult_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
  );

  seq_mult_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .add_a(w_add_a), .add_b(w_add_b), .add_cin(w_add_cin), .add_sum(w_add_sum), .add_cout(w_add_cout),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_prod(w_out_prod)
  );

  int checks = 0;
  int errors = 0;

  // Clocks are counted with the accept edge as clock 1.
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    return (BYP && (a == 8'd0 || b == 8'd0)) ? 1 : 9;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] prod, output int lat, output bit ready_leak);
    int guard;
    ready_leak = 1'b0;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    prod = out_prod;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_prod !== 16'd0) begin errors++; $display("FAIL reset_out_prod got=%0d exp=0", out_prod); end
    checks++; if (add_a !== 8'd0 || add_b !== 8'd0) begin errors++; $display("FAIL reset_adder got=%0d/%0d exp=0/0", add_a, add_b); end
    checks++; if (w_in_ready !== 1'b0 || w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_w16 got=%b/%b exp=0/0", w_in_ready, w_out_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic [7:0] a, b;
    logic [15:0] prod;
    int lat;
    bit leak;
    ta = '{8'd13, 8'd255, 8'd255, 8'd1};
    tb = '{8'd11, 8'd255, 8'd1, 8'd128};
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin a = ta[i]; b = tb[i]; end
      else begin a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255)); end
      run_op(a, b, prod, lat, leak);
      checks++; if (prod !== 16'(a) * 16'(b)) begin errors++; $display("FAIL basic_prod %0d*%0d got=%0d exp=%0d", a, b, prod, 16'(a) * 16'(b)); end
      checks++; if (lat !== exp_lat(a, b)) begin errors++; $display("FAIL basic_latency %0d*%0d got=%0d exp=%0d", a, b, lat, exp_lat(a, b)); end
      checks++; if (leak) begin errors++; $display("FAIL basic_in_ready_busy %0d*%0d got=1 exp=0", a, b); end
    end
  endtask

  task automatic test_zero();
    logic [15:0] prod;
    int lat;
    bit leak;
    for (int i = 0; i < 2; i++) begin
      logic [7:0] a, b;
      a = (i == 0) ? 8'd0 : 8'd77;
      b = (i == 0) ? 8'd77 : 8'd0;
      run_op(a, b, prod, lat, leak);
      checks++; if (prod !== 16'd0) begin errors++; $display("FAIL zero_prod %0d*%0d got=%0d exp=0", a, b, prod); end
      checks++; if (lat !== exp_lat(a, b)) begin errors++; $display("FAIL zero_latency %0d*%0d got=%0d exp=%0d", a, b, lat, exp_lat(a, b)); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    in_a = 8'd9; in_b = 8'd14; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (out_valid !== 1'b1 || out_prod !== 16'd126) begin errors++; $display("FAIL bp_first got=%b/%0d exp=1/126", out_valid, out_prod); end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~i[0];
      in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_prod !== 16'd126 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%b/%0d/%b exp=1/126/0", i, out_valid, out_prod, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_rst_mid();
    logic [15:0] prod;
    int lat, guard;
    bit leak;
    @(negedge clk);
    in_a = 8'd200; in_b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_during got=%b/%b exp=0/0", out_valid, in_ready); end
    checks++; if (out_prod !== 16'd0 || add_a !== 8'd0 || add_b !== 8'd0) begin errors++; $display("FAIL rst_mid_clear got=%0d/%0d/%0d exp=0/0/0", out_prod, add_a, add_b); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_release got=%b/%b exp=1/0", in_ready, out_valid); end
    run_op(8'd7, 8'd6, prod, lat, leak);
    checks++; if (prod !== 16'd42) begin errors++; $display("FAIL rst_mid_next got=%0d exp=42", prod); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL rst_mid_latency got=%0d exp=9", lat); end
  endtask

  function automatic logic [15:0] rnd_op(input int w);
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 9) == 0) r = 16'd0;
    if (w == 8) r[15:8] = 8'd0;
    return r;
  endfunction

  task automatic test_stream(input bit wide, input int nops);
    longint q[$];
    int w, cyc, last_acc, min_gap, done_cnt, limit;
    bit accepted, iv, ir, ov, orr, cin;
    logic [15:0] a, b;
    logic [31:0] prod;
    longint expv;
    w = wide ? 16 : 8;
    limit = nops * (w + 2) * 4;
    cyc = 0; last_acc = -1; min_gap = 0; done_cnt = 0; accepted = 1'b1;
    while (done_cnt < nops && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (accepted) begin a = rnd_op(w); b = rnd_op(w); end
      accepted = 1'b0;
      orr = ($urandom_range(0, 3) != 0);
      if (wide) begin
        w_in_valid = 1'b1; w_in_a = a; w_in_b = b; w_out_ready = orr;
        ir = w_in_ready; ov = w_out_valid; prod = w_out_prod; cin = w_add_cin;
      end else begin
        in_valid = 1'b1; in_a = a[7:0]; in_b = b[7:0]; out_ready = orr;
        ir = in_ready; ov = out_valid; prod = {16'd0, out_prod}; cin = add_cin;
      end
      iv = 1'b1;
      checks++; if (cin !== 1'b0) begin errors++; $display("FAIL stream_cin w=%0d got=%b exp=0", w, cin); end
      if (ov && orr) begin
        expv = (q.size() > 0) ? q.pop_front() : -1;
        checks++; if (longint'(prod) !== expv) begin errors++; $display("FAIL stream_prod w=%0d op=%0d got=%0d exp=%0d", w, done_cnt, prod, expv); end
        done_cnt++;
      end
      if (iv && ir) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc < min_gap) begin errors++; $display("FAIL stream_spacing w=%0d got=%0d exp>=%0d", w, cyc - last_acc, min_gap); end
        end
        q.push_back(longint'(a) * longint'(b));
        min_gap = (BYP && (a == 16'd0 || b == 16'd0)) ? 2 : w + 2;
        last_acc = cyc;
        accepted = 1'b1;
      end
    end
    checks++; if (done_cnt !== nops) begin errors++; $display("FAIL stream_timeout w=%0d got=%0d exp=%0d", w, done_cnt, nops); end
    @(negedge clk);
    in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b0; w_out_ready = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_rst_mid();
    test_stream(1'b0, 2000);
    test_stream(1'b1, 800);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
